// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin WISHBONE bus arbiter for up to NM masters. A two-state FSM
//   (IDLE / GRANT) drives registered one-hot grants plus the binary grant
//   index used by the interconnect master mux. A grant is held for the whole
//   bus cycle (while the owner keeps cyc high). On release, the grant hands
//   over directly to the next requester, with no idle cycle in between.
//
//   Optional stall watchdog, enabled with `define WB_ARB_WATCHDOG_EN:
//   wd_err_o pulses for one cycle after TO_CYCLES stalled strobe cycles.
//
// Parameters
//   NM         number of masters (2..8)
//   TO_CYCLES  watchdog stall limit in cycles (1..65535)
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   cyc_i      per-master cyc (bus request)
//   stb_i      per-master stb (watchdog only)
//   ack_i      slave ack (watchdog only)
//   err_i      slave err (watchdog only)
//   rty_i      slave rty (watchdog only)
//   gnt_o      one-hot grant, registered
//   gnt_idx_o  binary index of the granted master, registered
//   gnt_vld_o  a grant is active
//   wd_err_o   watchdog error pulse for the granted master

module wb_rr_arbiter #(
  parameter int NM        = 8,
  parameter int TO_CYCLES = 255,
  localparam int IW       = $clog2(NM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NM-1:0] cyc_i,
  input  logic [NM-1:0] stb_i,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic          rty_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o,
  output logic          wd_err_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] last_q;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic [NM-1:0] win_oh;

  // Round-robin scan starting at last+1. Walking from the farthest candidate
  // to the nearest lets the nearest requester overwrite the others, so no
  // early loop exit is needed. In a release cycle the owner's cyc is already
  // 0, so the owner cannot win its own hand-over.
  always_comb begin
    int p;
    p       = 0;
    win_vld = 1'b0;
    win_idx = last_q;
    for (int k = NM; k >= 1; k--) begin
      p = (int'(last_q) + k) % NM;
      if (cyc_i[p] == 1'b1) begin
        win_vld = 1'b1;
        win_idx = IW'(p);
      end
    end
  end

  assign win_oh = {{(NM-1){1'b0}}, 1'b1} << win_idx;

  // Only the owner's cyc is looked at while granted. X on the other
  // requests therefore cannot disturb a tenure that is in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      gnt_vld_o <= 1'b0;
      last_q    <= IW'(NM-1);
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= GRANT;
            gnt_o     <= win_oh;
            gnt_idx_o <= win_idx;
            gnt_vld_o <= 1'b1;
            last_q    <= win_idx;
          end
        end
        GRANT: begin
          if (cyc_i[gnt_idx_o] == 1'b0) begin
            if (win_vld) begin
              gnt_o     <= win_oh;
              gnt_idx_o <= win_idx;
              last_q    <= win_idx;
            end else begin
              state     <= IDLE;
              gnt_o     <= '0;
              gnt_vld_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        resp;
  logic        stall;
  logic        gnt_chg;

  assign resp  = ack_i | err_i | rty_i;
  assign stall = gnt_vld_o & stb_i[gnt_idx_o] & ~resp;

  // The grant changes at the next edge on a request from IDLE. It also
  // changes on any release, whether to another master or to IDLE.
  assign gnt_chg = (state == IDLE) ? win_vld : (cyc_i[gnt_idx_o] == 1'b0);

  // The count holds the number of stalled cycles before this one. The pulse
  // is therefore seen during the TO_CYCLES-th stalled cycle.
  assign wd_err_o = stall & (wd_cnt == 16'(TO_CYCLES-1));

  always_ff @(posedge clk_i) begin
    if (rst_i || gnt_chg || resp || wd_err_o) wd_cnt <= '0;
    else if (stall)                           wd_cnt <= wd_cnt + 16'd1;
  end
`else
  logic unused_wd;
  assign unused_wd = ^{stb_i, ack_i, err_i, rty_i};
  assign wd_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NM=8, TO_CYCLES=4).
// The stimulus drives inputs #1 after each rising edge. It also queues the
// outputs expected during that cycle. A monitor pops the queue on the
// falling edge and compares.
module tb_wb_rr_arbiter;
  localparam int NM = 8;
`ifdef WB_ARB_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NM-1:0] cyc = '0;
  logic [NM-1:0] stb = '0;
  logic          ack = 1'b0;
  logic          err = 1'b0;
  logic          rty = 1'b0;
  logic [NM-1:0] gnt;
  logic [2:0]    gnt_idx;
  logic          gnt_vld;
  logic          wd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NM-1:0] gnt;
    logic          vld;
    logic          wd;
    string         name;
  } exp_t;

  exp_t q[$];

  wb_rr_arbiter #(.NM(NM), .TO_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb),
    .ack_i(ack), .err_i(err), .rty_i(rty),
    .gnt_o(gnt), .gnt_idx_o(gnt_idx), .gnt_vld_o(gnt_vld), .wd_err_o(wd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] oh2idx(input logic [NM-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NM; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt_vld !== e.vld || wd_err !== e.wd ||
          (e.vld && gnt_idx !== oh2idx(e.gnt))) begin
        errors++;
        $display("FAIL %s: got gnt=%h idx=%0d vld=%b wd=%b, want gnt=%h idx=%0d vld=%b wd=%b",
                 e.name, gnt, gnt_idx, gnt_vld, wd_err, e.gnt, oh2idx(e.gnt), e.vld, e.wd);
      end
    end
  end

  task automatic step(input logic r, input logic [NM-1:0] c, input logic [NM-1:0] s,
                      input logic a, input logic [NM-1:0] eg, input logic ew,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cyc = c; stb = s; ack = a;
    e.gnt = eg; e.vld = |eg; e.wd = ew; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    logic [NM-1:0] xc;
    logic [NM-1:0] m;
    // reset state
    step(1, 8'h00, 8'h00, 0, 8'h00, 0, "reset0");
    step(0, 8'h00, 8'h00, 0, 8'h00, 0, "reset1");

    // 1: first grant, latency 1, stable hold
    step(0, 8'h06, 8'h00, 0, 8'h00, 0, "t1_req");
    for (int i = 0; i < 5; i++) step(0, 8'h06, 8'h00, 0, 8'h02, 0, "t1_hold");

    // 2: direct hand-over without idle, other requests wait
    step(0, 8'h86, 8'h00, 0, 8'h02, 0, "t2_wait");
    step(0, 8'h86, 8'h00, 0, 8'h02, 0, "t2_wait");
    step(0, 8'h84, 8'h00, 0, 8'h02, 0, "t2_release");
    step(0, 8'h84, 8'h00, 0, 8'h04, 0, "t2_handover");
    step(0, 8'h00, 8'h00, 0, 8'h04, 0, "t2_release2");
    step(0, 8'h00, 8'h00, 0, 8'h00, 0, "t2_idle");

    // 3: all request, 3-cycle tenures, order 0..7,0
    step(1, 8'h00, 8'h00, 0, 8'h00, 0, "t3_rst");
    step(0, 8'hFF, 8'h00, 0, 8'h00, 0, "t3_req");
    for (int k = 0; k <= 8; k++) begin
      m = 8'h01 << (k % 8);
      step(0, 8'hFF, 8'h00, 0, m, 0, "t3_tenure");
      step(0, 8'hFF, 8'h00, 0, m, 0, "t3_tenure");
      step(0, (k == 8) ? 8'h00 : (8'hFF & ~m), 8'h00, 0, m, 0, "t3_release");
    end
    step(0, 8'h00, 8'h00, 0, 8'h00, 0, "t3_idle");

    // 4: single requester re-requests after one cycle off
    step(0, 8'h08, 8'h00, 0, 8'h00, 0, "t4_req");
    step(0, 8'h08, 8'h00, 0, 8'h08, 0, "t4_gnt");
    step(0, 8'h08, 8'h00, 0, 8'h08, 0, "t4_hold");
    step(0, 8'h00, 8'h00, 0, 8'h08, 0, "t4_release");
    step(0, 8'h08, 8'h00, 0, 8'h00, 0, "t4_idle_gap");
    step(0, 8'h08, 8'h00, 0, 8'h08, 0, "t4_regrant");
    // X on non-owners must not disturb the tenure
    xc = 8'bxxxx1xxx;
    step(0, xc, 8'h00, 0, 8'h08, 0, "x_hold");
    step(0, xc, 8'h00, 0, 8'h08, 0, "x_hold");
    step(0, 8'h08, 8'h00, 0, 8'h08, 0, "x_after");

    // 5: watchdog pulse in 4th stalled cycle only, none when acked
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_s1");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_s2");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_s3");
    step(0, 8'h08, 8'h08, 0, 8'h08, WD, "t5_s4");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_s5");
    step(0, 8'h08, 8'h00, 0, 8'h08, 0,  "t5_nostb");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_a_s1");
    step(0, 8'h08, 8'h08, 1, 8'h08, 0,  "t5_a_ack");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_a_s3");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_a_s4");
    step(0, 8'h08, 8'h08, 0, 8'h08, 0,  "t5_a_s5");
    step(0, 8'h08, 8'h00, 0, 8'h08, 0,  "t5_a_end");

    // 6: reset mid-tenure, then master 0 has top priority
    step(0, 8'h00, 8'h00, 0, 8'h08, 0, "t6_release");
    step(0, 8'h20, 8'h00, 0, 8'h00, 0, "t6_req");
    step(0, 8'h20, 8'h00, 0, 8'h20, 0, "t6_gnt");
    step(1, 8'h20, 8'h00, 0, 8'h20, 0, "t6_rst_cycle");
    step(0, 8'hFF, 8'h00, 0, 8'h00, 0, "t6_after_rst");
    step(0, 8'hFF, 8'h00, 0, 8'h01, 0, "t6_m0");
    step(0, 8'hFF, 8'h00, 0, 8'h01, 0, "t6_m0_hold");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
